// File: rtl/restoring_divider_pkg.sv
// Shared arithmetic back-end definitions.
// State encodings and default width for divider (and later multiplier).
package restoring_divider_pkg;

  localparam int DIV_WIDTH = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Counter width able to hold 0..w.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/restoring_divider_addsub.sv
// Ripple-carry add/subtract cell shared with the add/sub unit.
// Subtract: a + ~b + 1; borrow is the inverted carry out.
module div_addsub #(
  parameter int N = 5
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         sub_i,
  output logic [N-1:0] res_o,
  output logic         borrow_o
);

  logic [N:0]   c;
  logic [N-1:0] bx;

  assign bx   = b_i ^ {N{sub_i}};
  assign c[0] = sub_i;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign res_o[i] = a_i[i] ^ bx[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & bx[i])
                    | (c[i] & (a_i[i] ^ bx[i]));
  end

  assign borrow_o = sub_i & ~c[N];

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Dividend is shifted out of Q into R; trial subtract decides each bit.
module restoring_divider
  import restoring_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivZero
);

  localparam int CW = cnt_width(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   t;
  logic             borrow;
  logic [WIDTH-1:0] q_nx;
  logic [WIDTH:0]   r_nx;
  logic             last;

  assign r_sh = {r_q[WIDTH-1:0], q_q[WIDTH-1]};

  div_addsub #(
    .N (WIDTH + 1)
  ) u_addsub (
    .a_i      (r_sh),
    .b_i      ({1'b0, d_q}),
    .sub_i    (1'b1),
    .res_o    (t),
    .borrow_o (borrow)
  );

  assign q_nx = {q_q[WIDTH-2:0], ~borrow};
  assign r_nx = borrow ? r_sh : t;
  assign last = (cnt_q == CW'(WIDTH - 1));

  // Next-state: accept, iterate, publish results.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    unique case (1'b1)
      (state_q == ST_IDLE): begin
        if (Start) begin
          d_d   = Divisor;
          q_d   = Dividend;
          r_d   = '0;
          cnt_d = '0;
          if (Divisor == '0) begin
            quo_d   = '1;
            rem_d   = Dividend;
            dz_d    = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      (state_q == ST_RUN): begin
        q_d   = q_nx;
        r_d   = r_nx;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          quo_d   = q_nx;
          rem_d   = r_nx[WIDTH-1:0];
          dz_d    = 1'b0;
          state_d = ST_DONE;
        end
      end
      (state_q == ST_DONE): begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  assign Busy      = (state_q != ST_IDLE);
  assign Done      = (state_q == ST_DONE);
  assign Quotient  = quo_q;
  assign Remainder = rem_q;
  assign DivZero   = dz_q;

endmodule
